// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package seq_tx_pkg;

    localparam int unsigned DEF_MAX_LEN = 16;
    localparam int unsigned DEF_LEN_W   = 5;
    localparam int unsigned DEF_REP_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } seq_tx_state_t;

endpackage

// File: rtl/seq_pattern_tx_piso_shift.sv
// Loadable parallel-in serial-out register; presents the bit that the
// index will point at after this cycle's load/reload/step.
module piso_shift
    import seq_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_MAX_LEN,
    parameter int unsigned IDX_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             reload,
    input  logic             step,
    input  logic [WIDTH-1:0] data_in,
    input  logic [IDX_W-1:0] top_in,
    output logic             next_bit,
    output logic             idx_zero
);

    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] top;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel;
    logic [WIDTH-1:0] src;

    // Look-ahead select lets the owner register the serial bit directly.
    always_comb begin
        sel = idx - IDX_W'(1);
        src = data;
        if (load) begin
            sel = top_in;
            src = data_in;
        end else if (reload) begin
            sel = top;
        end
        next_bit = |(src & (WIDTH'(1) << sel));
    end

    assign idx_zero = (idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            top  <= '0;
            idx  <= '0;
        end else if (load) begin
            data <= data_in;
            top  <= top_in;
            idx  <= top_in;
        end else if (reload) begin
            idx <= top;
        end else if (step) begin
            idx <= idx - IDX_W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, with
// repeats separated by an idle gap, and pulses done/err at frame end.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned REP_W   = DEF_REP_W,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   reps,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    seq_tx_state_t    state, state_nxt;
    logic [REP_W-1:0] rep_cnt, rep_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             x_nxt, xv_nxt, done_nxt, err_nxt;
    logic             load, reload, step;
    logic             next_bit, idx_zero;
    logic             len_ok;
    logic [LEN_W-1:0] top_idx;
    logic [REP_W-1:0] reps_eff;

    assign len_ok   = (len != '0) && (len <= MAX_LEN_L);
    assign top_idx  = len - LEN_W'(1);
    assign reps_eff = (reps == '0) ? REP_W'(1) : reps;

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    piso_shift #(
        .WIDTH (MAX_LEN),
        .IDX_W (LEN_W)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .reload   (reload),
        .step     (step),
        .data_in  (pattern),
        .top_in   (top_idx),
        .next_bit (next_bit),
        .idx_zero (idx_zero)
    );

    always_comb begin
        state_nxt = state;
        rep_nxt   = rep_cnt;
        gap_nxt   = gap_cnt;
        x_nxt     = 1'b0;
        xv_nxt    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        load      = 1'b0;
        reload    = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    if (len_ok) begin
                        load      = 1'b1;
                        state_nxt = SEND;
                        rep_nxt   = reps_eff;
                        x_nxt     = next_bit;
                        xv_nxt    = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!idx_zero) begin
                    step   = 1'b1;
                    x_nxt  = next_bit;
                    xv_nxt = 1'b1;
                end else if (rep_cnt > REP_W'(1)) begin
                    rep_nxt = rep_cnt - REP_W'(1);
                    if (GAP_LEN > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_LOAD;
                    end else begin
                        reload = 1'b1;
                        x_nxt  = next_bit;
                        xv_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                    rep_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    reload    = 1'b1;
                    state_nxt = SEND;
                    x_nxt     = next_bit;
                    xv_nxt    = 1'b1;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rep_cnt <= '0;
            gap_cnt <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            rep_cnt <= rep_nxt;
            gap_cnt <= gap_nxt;
            x       <= x_nxt;
            x_valid <= xv_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: frame-list model compared every cycle, plus
// directed frames with hand-computed literal expectations.
module tb_seq_pattern_tx;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic [3:0]  reps = '0;
    logic        x, x_valid, busy, done, err;

    int total = 0;
    int bad   = 0;

    seq_pattern_tx #(
        .MAX_LEN (16),
        .LEN_W   (5),
        .REP_W   (4),
        .GAP_LEN (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len         (len),
        .reps        (reps),
        .x           (x),
        .x_valid     (x_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted request expands into the list of per-cycle outputs.
    typedef struct packed {
        logic xv;
        logic x;
        logic done;
        logic err;
        logic busy;
    } rec_t;

    rec_t q[$];
    rec_t cur;

    task automatic build(input logic [15:0] p, input int l, input int rp);
        rec_t r;
        int re;
        re = (rp == 0) ? 1 : rp;
        if (l < 1 || l > 16) begin
            r = '0; r.done = 1'b1; r.err = 1'b1;
            q.push_back(r);
        end else begin
            for (int rr = 0; rr < re; rr++) begin
                for (int k = l - 1; k >= 0; k--) begin
                    r = '0; r.xv = 1'b1; r.x = p[k]; r.busy = 1'b1;
                    q.push_back(r);
                end
                if (rr < re - 1) begin
                    for (int g = 0; g < GAP; g++) begin
                        r = '0; r.busy = 1'b1;
                        q.push_back(r);
                    end
                end
            end
            r = '0; r.done = 1'b1;
            q.push_back(r);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            cur <= '0;
        end else begin
            if (start_valid && !cur.busy)
                build(pattern, int'(len), int'(reps));
            cur <= (q.size() != 0) ? q.pop_front() : rec_t'('0);
        end
    end

    always @(negedge clk) begin
        chk("x_valid", 64'(x_valid), 64'(cur.xv));
        chk("x", 64'(x), 64'(cur.x));
        chk("done", 64'(done), 64'(cur.done));
        chk("err", 64'(err), 64'(cur.err));
        chk("busy", 64'(busy), 64'(cur.busy));
        chk("start_ready", 64'(start_ready), 64'(!cur.busy));
    end

    task automatic send(input logic [15:0] p, input logic [4:0] l, input logic [3:0] rp);
        pattern     = p;
        len         = l;
        reps        = rp;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    // Observes n cycles after the handshake edge (cycle 1 = first cycle after it).
    task automatic collect(input int n, input int drop_at,
                           output logic [63:0] bits, output int nv, output int first_v,
                           output int done_n, output int done_first, output int done_last,
                           output int v_after, output int det, output int errs, output int rlow);
        logic [3:0] win;
        bits = '0; win = '0;
        nv = 0; first_v = 0; done_n = 0; done_first = 0; done_last = 0;
        v_after = 0; det = 0; errs = 0; rlow = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == drop_at) start_valid = 1'b0;
            if (x_valid) begin
                bits = {bits[62:0], x};
                nv++;
                win = {win[2:0], x};
                if (nv >= 4 && win == 4'b1011) det++;
                if (first_v == 0) first_v = c;
                if (done_n > 0 && v_after == 0) v_after = c;
            end
            if (done) begin
                done_n++;
                if (done_first == 0) done_first = c;
                done_last = c;
                if (err) errs++;
            end
            if (!start_ready) rlow++;
        end
    endtask

    initial begin
        logic [63:0] bits;
        int nv, fv, dn, df, dl, va, det, errs, rlow;

        repeat (2) @(negedge clk);
        chk("rst_x_valid", 64'(x_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(start_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic frame
        send(16'h000B, 5'd4, 4'd1);
        collect(8, 0, bits, nv, fv, dn, df, dl, va, det, errs, rlow);
        chk("basic_bits", bits, 64'hB);
        chk("basic_nv", 64'(nv), 64'd4);
        chk("basic_first", 64'(fv), 64'd1);
        chk("basic_done_cyc", 64'(df), 64'd5);
        chk("basic_done_n", 64'(dn), 64'd1);
        chk("basic_err", 64'(errs), 64'd0);

        // repeats with gap
        send(16'h000B, 5'd4, 4'd3);
        collect(20, 0, bits, nv, fv, dn, df, dl, va, det, errs, rlow);
        chk("rep_bits", bits, 64'hBBB);
        chk("rep_nv", 64'(nv), 64'd12);
        chk("rep_done_cyc", 64'(df), 64'd17);
        chk("rep_detect", 64'(det), 64'd3);
        chk("rep_err", 64'(errs), 64'd0);

        // full width, reps = 0
        send(16'hA5C3, 5'd16, 4'd0);
        collect(20, 0, bits, nv, fv, dn, df, dl, va, det, errs, rlow);
        chk("full_bits", bits, 64'hA5C3);
        chk("full_nv", 64'(nv), 64'd16);
        chk("full_done_cyc", 64'(df), 64'd17);
        chk("full_done_n", 64'(dn), 64'd1);

        // illegal lengths
        send(16'hFFFF, 5'd0, 4'd1);
        collect(3, 0, bits, nv, fv, dn, df, dl, va, det, errs, rlow);
        chk("len0_nv", 64'(nv), 64'd0);
        chk("len0_done_cyc", 64'(df), 64'd1);
        chk("len0_err", 64'(errs), 64'd1);
        chk("len0_ready_low", 64'(rlow), 64'd0);
        send(16'hFFFF, 5'd17, 4'd2);
        collect(3, 0, bits, nv, fv, dn, df, dl, va, det, errs, rlow);
        chk("len17_nv", 64'(nv), 64'd0);
        chk("len17_done_cyc", 64'(df), 64'd1);
        chk("len17_err", 64'(errs), 64'd1);
        chk("len17_ready_low", 64'(rlow), 64'd0);

        // async reset in the third bit cycle
        send(16'h000B, 5'd4, 4'd1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_x_valid", 64'(x_valid), 64'd1);
        chk("pre_rst_x", 64'(x), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_x_valid", 64'(x_valid), 64'd0);
        chk("async_x", 64'(x), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(16'h0006, 5'd4, 4'd1);
        collect(8, 0, bits, nv, fv, dn, df, dl, va, det, errs, rlow);
        chk("post_rst_bits", bits, 64'h6);
        chk("post_rst_first", 64'(fv), 64'd1);
        chk("post_rst_done_cyc", 64'(df), 64'd5);

        // back-to-back with start_valid held high
        pattern     = 16'h000B;
        len         = 5'd4;
        reps        = 4'd1;
        start_valid = 1'b1;
        @(posedge clk);
        #1 pattern = 16'h0006;
        collect(14, 6, bits, nv, fv, dn, df, dl, va, det, errs, rlow);
        chk("b2b_bits", bits, 64'hB6);
        chk("b2b_nv", 64'(nv), 64'd8);
        chk("b2b_done_first", 64'(df), 64'd5);
        chk("b2b_second_first_bit", 64'(va), 64'd6);
        chk("b2b_done_last", 64'(dl), 64'd10);
        chk("b2b_done_n", 64'(dn), 64'd2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the driving end of the single-bit serial stream that the sequence detectors consume. It accepts a pattern word, a length and a repeat count through a valid/ready handshake. It then emits the pattern MSB-first, one bit per clock, with an optional idle gap between repeats, and pulses `done` when the frame ends. It replaces hand-written `@(posedge clk) x <= …` stimulus and serves as an on-chip test-pattern source.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum pattern length in bits.
- `LEN_W`, 5: width of `len`; must satisfy 2^LEN_W > MAX_LEN.
- `REP_W`, 4: width of `reps`.
- `GAP_LEN`, 2: idle cycles between repeats; 0 gives back-to-back repeats.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start_valid`, input, 1: a request is present.
- `start_ready`, output, 1: block can accept a request; high only in IDLE.
- `pattern`, input, MAX_LEN: pattern bits, right-aligned; bit `len-1` is sent first.
- `len`, input, LEN_W: number of bits to send; legal range 1..MAX_LEN.
- `reps`, input, REP_W: total transmissions; 0 is treated as 1.
- `x`, output, 1: serial data; 0 whenever `x_valid` is 0.
- `x_valid`, output, 1: `x` carries a pattern bit this cycle.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse at end of frame.
- `err`, output, 1: qualifies `done`; set for an illegal `len`.

## Operation
- States: IDLE, SEND, GAP. The typedef lives in the package.
- **IDLE**
  - On `start_valid && start_ready`, latch `pattern`, `len` and `max(reps,1)`.
  - If `len` is in 1..MAX_LEN: load the bit index to `len-1`, go to SEND.
  - Otherwise: stay in IDLE and pulse `done=1`, `err=1` in the next cycle; no bits are sent.
- **SEND**
  - Each cycle `x = pattern[idx]` and `x_valid = 1`; `idx` decrements.
  - When `idx` is 0 and repeats remain:
    - with GAP_LEN > 0, go to GAP;
    - with GAP_LEN = 0, reload `idx = len-1` and stay in SEND.
  - When `idx` is 0 on the last repeat: go to IDLE and pulse `done` (`err = 0`).
- **GAP**: hold `x = 0`, `x_valid = 0` for exactly GAP_LEN cycles, then reload `idx` and go to SEND.
- Inputs are ignored while not in IDLE; changes to `pattern` mid-frame have no effect.
- Reset, asserted any time (including mid-frame):
  - outputs go immediately to `x = 0`, `x_valid = 0`, `done = 0`, `err = 0`, `busy = 0`, `start_ready = 1`;
  - all counters clear and the state returns to IDLE;
  - a partial frame is abandoned with no `done` pulse.
- Counters:
  - `idx` is LEN_W bits wide;
  - the repeat counter is REP_W bits wide and saturates on the decrement to 0;
  - the gap counter is $clog2(GAP_LEN+1) bits wide, minimum 1.

## Timing
- `x`, `x_valid`, `done` and `err` are registered. `start_ready` and `busy` are decoded from the state register.
- The handshake completes at rising edge E. Bit k of repeat r is valid in the cycle following edge E + k + r·(len + GAP_LEN).
- Frame duration is reps·len + (reps−1)·GAP_LEN cycles of activity. `done` is high in the single cycle after the last bit, with `x_valid = 0` in that cycle.
- `start_ready` is high during the `done` cycle, so a new request can be accepted there. The minimum spacing between the last bit of one frame and the first bit of the next is one idle cycle.
- An illegal `len` gives `done` and `err` in the cycle after E; `start_ready` stays high throughout.

## Structure
- Package `seq_tx_pkg` holds:
  - the `seq_tx_state_t` enum {IDLE, SEND, GAP};
  - default constants for `MAX_LEN`, `LEN_W` and `REP_W`.
- One sub-module: `piso_shift`, a loadable parallel-in serial-out register with index select.
- The FSM and the repeat and gap counters stay in the top module.

## Test plan
- Basic frame: `pattern = 16'h000B`, `len = 4`, `reps = 1` → `x` = 1,0,1,1 on four consecutive valid cycles starting the cycle after the handshake; `done` in cycle 5, `err = 0`.
- Repeats with gap: `pattern = 16'h000B`, `len = 4`, `reps = 3`, `GAP_LEN = 2` → 1011, two invalid cycles, 1011, two invalid cycles, 1011; `done` after 16 cycles. Drive the detector from `x` and check three detections.
- Full width and zero reps: `pattern = 16'hA5C3`, `len = 16`, `reps = 0` → the 16 bits 1010010111000011 once; `done` in cycle 17.
- Illegal length: `len = 0`, then `len = 17` → `done = 1` and `err = 1` one cycle after each handshake; `x_valid` never rises; `start_ready` is never low.
- Async reset mid-frame: assert `reset` between clock edges after 2 of 4 bits → `x`, `x_valid` and `busy` go low immediately with no clock edge needed; no `done`; a fresh request after release transmits correctly from its first bit.
- Back-to-back: hold `start_valid` high with a second pattern (`4'b0110`) → it is accepted in the `done` cycle of frame 1 and its first bit appears in the next cycle (exactly one idle cycle).
